// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Registered control FSM for a shared-memory multi-cycle MIPS
//               datapath (add/sub/and/or/slt/jr, lw, sw, beq, bne, j, jal,
//               addi, andi). Sequences fetch/decode/execute/memory/write-back,
//               optionally waits on a memory ready handshake, traps illegal
//               instructions and counts retired instructions.
// Ports       : clk, rst (async, active-high)
//               opcode/func  - IR fields, held by the IR from DECODE to retire
//               ZERO         - ALU zero flag (branch resolution)
//               mem_ready    - memory completes this cycle (MEM_HS = 1 only)
//               i_or_d, mem_read, mem_write, ir_write        - memory/IR
//               reg_dst, jal_reg, pc_to_reg, mem_to_reg, reg_write - reg file
//               alu_src_a, alu_src_b, alu_operation          - ALU
//               pc_source, pc_write                          - PC update
//               illegal (sticky trap), instr_count (retired count)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int MEM_HS = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             ZERO,
    input  logic             mem_ready,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             jal_reg,
    output logic             pc_to_reg,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_operation,
    output logic [1:0]       pc_source,
    output logic             pc_write,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    // State encoding
    localparam logic [3:0] c_ST_FETCH    = 4'd0;
    localparam logic [3:0] c_ST_DECODE   = 4'd1;
    localparam logic [3:0] c_ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] c_ST_MEM_RD   = 4'd3;
    localparam logic [3:0] c_ST_MEM_WB   = 4'd4;
    localparam logic [3:0] c_ST_MEM_WR   = 4'd5;
    localparam logic [3:0] c_ST_R_EXEC   = 4'd6;
    localparam logic [3:0] c_ST_R_WB     = 4'd7;
    localparam logic [3:0] c_ST_I_EXEC   = 4'd8;
    localparam logic [3:0] c_ST_I_WB     = 4'd9;
    localparam logic [3:0] c_ST_BRANCH   = 4'd10;
    localparam logic [3:0] c_ST_JUMP     = 4'd11;
    localparam logic [3:0] c_ST_JAL      = 4'd12;
    localparam logic [3:0] c_ST_JR       = 4'd13;
    localparam logic [3:0] c_ST_TRAP     = 4'd14;

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] c_FN_JR  = 6'b001000;
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    // ALU operations
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             w_retire;
    logic             w_mem_done;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instr_count;

    // Without the handshake every memory access completes in one cycle.
    assign w_mem_done = (MEM_HS != 0) ? mem_ready : 1'b1;

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        jal_reg       = 1'b0;
        pc_to_reg     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_operation = c_ALU_ADD;
        pc_source     = 2'b00;
        pc_write      = 1'b0;

        case (r_state)
            c_ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (w_mem_done) begin
                    // Reset forces FETCH asynchronously; block the PC/IR
                    // load strobes until reset has been released.
                    ir_write = ~rst;
                    pc_write = ~rst;
                    w_next   = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    c_OP_LW, c_OP_SW:    w_next = c_ST_MEM_ADDR;
                    c_OP_RTYPE:          w_next = (func == c_FN_JR) ? c_ST_JR : c_ST_R_EXEC;
                    c_OP_ADDI, c_OP_ANDI: w_next = c_ST_I_EXEC;
                    c_OP_BEQ, c_OP_BNE:  w_next = c_ST_BRANCH;
                    c_OP_J:              w_next = c_ST_JUMP;
                    c_OP_JAL:            w_next = c_ST_JAL;
                    default:             w_next = c_ST_TRAP;
                endcase
            end
            c_ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (opcode == c_OP_SW) ? c_ST_MEM_WR : c_ST_MEM_RD;
            end
            c_ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (w_mem_done) begin
                    w_next = c_ST_MEM_WB;
                end
            end
            c_ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_retire   = 1'b1;
                w_next     = c_ST_FETCH;
            end
            c_ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (w_mem_done) begin
                    w_retire = 1'b1;
                    w_next   = c_ST_FETCH;
                end
            end
            c_ST_R_EXEC: begin
                alu_src_a = 1'b1;
                w_next    = c_ST_R_WB;
                case (func)
                    c_FN_ADD: alu_operation = c_ALU_ADD;
                    c_FN_SUB: alu_operation = c_ALU_SUB;
                    c_FN_AND: alu_operation = c_ALU_AND;
                    c_FN_OR:  alu_operation = c_ALU_OR;
                    c_FN_SLT: alu_operation = c_ALU_SLT;
                    default:  w_next        = c_ST_TRAP;
                endcase
            end
            c_ST_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = c_ST_FETCH;
            end
            c_ST_I_EXEC: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_operation = (opcode == c_OP_ANDI) ? c_ALU_AND : c_ALU_ADD;
                w_next        = c_ST_I_WB;
            end
            c_ST_I_WB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = c_ST_FETCH;
            end
            c_ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_operation = c_ALU_SUB;
                pc_source     = 2'b01;
                pc_write      = (opcode == c_OP_BNE) ? ~ZERO : ZERO;
                w_retire      = 1'b1;
                w_next        = c_ST_FETCH;
            end
            c_ST_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                w_retire  = 1'b1;
                w_next    = c_ST_FETCH;
            end
            c_ST_JAL: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                jal_reg   = 1'b1;
                pc_to_reg = 1'b1;
                w_retire  = 1'b1;
                w_next    = c_ST_FETCH;
            end
            c_ST_JR: begin
                pc_source = 2'b11;
                pc_write  = 1'b1;
                w_retire  = 1'b1;
                w_next    = c_ST_FETCH;
            end
            c_ST_TRAP: begin
                // Locked until reset.
                w_next = c_ST_TRAP;
            end
            default: begin
                w_next = c_ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_FETCH;
            r_illegal     <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            // Set on entry to TRAP so the flag coincides with the trap state.
            if (w_next == c_ST_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_instr_count <= r_instr_count + c_CNT_ONE;
            end
        end
    end

    assign illegal     = r_illegal;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller.
//               dut  : MEM_HS = 1, CNT_W = 16
//               dut2 : MEM_HS = 0, CNT_W = 2 (own reset, shares other inputs)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst2 = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] func = 6'd0;
    logic       ZERO = 1'b0;
    logic       mem_ready = 1'b0;

    logic        i_or_d, mem_read, mem_write, ir_write, reg_dst, jal_reg;
    logic        pc_to_reg, mem_to_reg, reg_write, alu_src_a, pc_write, illegal;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_operation;
    logic [15:0] instr_count;

    logic        i_or_d2, mem_read2, mem_write2, ir_write2, reg_dst2, jal_reg2;
    logic        pc_to_reg2, mem_to_reg2, reg_write2, alu_src_a2, pc_write2, illegal2;
    logic [1:0]  alu_src_b2, pc_source2;
    logic [2:0]  alu_operation2;
    logic [1:0]  instr_count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_HS(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .ZERO(ZERO),
        .mem_ready(mem_ready), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .jal_reg(jal_reg), .pc_to_reg(pc_to_reg), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_operation(alu_operation), .pc_source(pc_source),
        .pc_write(pc_write), .illegal(illegal), .instr_count(instr_count)
    );

    multicycle_controller #(.MEM_HS(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .opcode(opcode), .func(func), .ZERO(ZERO),
        .mem_ready(mem_ready), .i_or_d(i_or_d2), .mem_read(mem_read2),
        .mem_write(mem_write2), .ir_write(ir_write2), .reg_dst(reg_dst2),
        .jal_reg(jal_reg2), .pc_to_reg(pc_to_reg2), .mem_to_reg(mem_to_reg2),
        .reg_write(reg_write2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
        .alu_operation(alu_operation2), .pc_source(pc_source2),
        .pc_write(pc_write2), .illegal(illegal2), .instr_count(instr_count2)
    );

    // Packed view of all strobes: {i_or_d, mem_read, mem_write, ir_write,
    // reg_dst, jal_reg, pc_to_reg, mem_to_reg, reg_write, alu_src_a,
    // alu_src_b[1:0], alu_operation[2:0], pc_source[1:0], pc_write}
    logic [17:0] w_outv, w_outv2;
    assign w_outv  = {i_or_d, mem_read, mem_write, ir_write, reg_dst, jal_reg,
                      pc_to_reg, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                      alu_operation, pc_source, pc_write};
    assign w_outv2 = {i_or_d2, mem_read2, mem_write2, ir_write2, reg_dst2, jal_reg2,
                      pc_to_reg2, mem_to_reg2, reg_write2, alu_src_a2, alu_src_b2,
                      alu_operation2, pc_source2, pc_write2};

    function automatic logic [17:0] ov(
        input logic iord, input logic mr, input logic mw, input logic irw,
        input logic rd, input logic jl, input logic p2r, input logic m2r,
        input logic rw, input logic sa, input logic [1:0] sb,
        input logic [2:0] op, input logic [1:0] ps, input logic pw);
        return {iord, mr, mw, irw, rd, jl, p2r, m2r, rw, sa, sb, op, ps, pw};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check dut strobes for the current state, then advance one clock.
    task automatic cyc(input string tag, input logic [17:0] exp);
        #1;
        chk(tag, {14'd0, w_outv}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input string tag, input logic [17:0] exp);
        #1;
        chk(tag, {14'd0, w_outv2}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    logic [17:0] v_rst, v_fetch, v_dec, v_maddr, v_mrd, v_mwb, v_mwr;
    logic [17:0] v_radd, v_rsub, v_rwb, v_iadd, v_iand, v_iwb;
    logic [17:0] v_br_t, v_br_n, v_jal, v_jump, v_jr, v_trap;

    initial begin
        v_rst   = ov(0,1,0,0, 0,0,0,0,0, 0,2'b01,3'b010,2'b00,0);
        v_fetch = ov(0,1,0,1, 0,0,0,0,0, 0,2'b01,3'b010,2'b00,1);
        v_dec   = ov(0,0,0,0, 0,0,0,0,0, 0,2'b11,3'b010,2'b00,0);
        v_maddr = ov(0,0,0,0, 0,0,0,0,0, 1,2'b10,3'b010,2'b00,0);
        v_mrd   = ov(1,1,0,0, 0,0,0,0,0, 0,2'b00,3'b010,2'b00,0);
        v_mwb   = ov(0,0,0,0, 0,0,0,1,1, 0,2'b00,3'b010,2'b00,0);
        v_mwr   = ov(1,0,1,0, 0,0,0,0,0, 0,2'b00,3'b010,2'b00,0);
        v_radd  = ov(0,0,0,0, 0,0,0,0,0, 1,2'b00,3'b010,2'b00,0);
        v_rsub  = ov(0,0,0,0, 0,0,0,0,0, 1,2'b00,3'b110,2'b00,0);
        v_rwb   = ov(0,0,0,0, 1,0,0,0,1, 0,2'b00,3'b010,2'b00,0);
        v_iadd  = ov(0,0,0,0, 0,0,0,0,0, 1,2'b10,3'b010,2'b00,0);
        v_iand  = ov(0,0,0,0, 0,0,0,0,0, 1,2'b10,3'b000,2'b00,0);
        v_iwb   = ov(0,0,0,0, 0,0,0,0,1, 0,2'b00,3'b010,2'b00,0);
        v_br_t  = ov(0,0,0,0, 0,0,0,0,0, 1,2'b00,3'b110,2'b01,1);
        v_br_n  = ov(0,0,0,0, 0,0,0,0,0, 1,2'b00,3'b110,2'b01,0);
        v_jal   = ov(0,0,0,0, 0,1,1,0,1, 0,2'b00,3'b010,2'b10,1);
        v_jump  = ov(0,0,0,0, 0,0,0,0,0, 0,2'b00,3'b010,2'b10,1);
        v_jr    = ov(0,0,0,0, 0,0,0,0,0, 0,2'b00,3'b010,2'b11,1);
        v_trap  = ov(0,0,0,0, 0,0,0,0,0, 0,2'b00,3'b010,2'b00,0);

        // Asynchronous reset before any clock edge; mem_ready high must not
        // produce PC/IR load strobes while reset is held.
        mem_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_outputs", {14'd0, w_outv}, {14'd0, v_rst});
        chk("rst_count", {16'd0, instr_count}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_outputs", {14'd0, w_outv}, {14'd0, v_rst});
        @(posedge clk);
        #1;
        rst = 1'b0;

        // add: FETCH, DECODE, R_EXEC, R_WB
        opcode = 6'b000000; func = 6'b100000;
        cyc("add_fetch", v_fetch);
        cyc("add_decode", v_dec);
        cyc("add_rexec", v_radd);
        cyc("add_rwb", v_rwb);
        chk("add_count", {16'd0, instr_count}, 32'd1);

        // sub: ALU op from func
        func = 6'b100010;
        cyc("sub_fetch", v_fetch);
        cyc("sub_decode", v_dec);
        cyc("sub_rexec", v_rsub);
        cyc("sub_rwb", v_rwb);
        chk("sub_count", {16'd0, instr_count}, 32'd2);

        // lw with two wait cycles in MEM_RD: 7 cycles total
        opcode = 6'b100011; func = 6'b000000;
        cyc("lw_fetch", v_fetch);
        cyc("lw_decode", v_dec);
        cyc("lw_maddr", v_maddr);
        mem_ready = 1'b0;
        cyc("lw_rd_wait1", v_mrd);
        cyc("lw_rd_wait2", v_mrd);
        mem_ready = 1'b1;
        cyc("lw_rd_done", v_mrd);
        cyc("lw_wb", v_mwb);
        chk("lw_count", {16'd0, instr_count}, 32'd3);

        // sw with a fetch wait and a write wait
        opcode = 6'b101011;
        mem_ready = 1'b0;
        cyc("sw_fetch_wait", v_rst);
        mem_ready = 1'b1;
        cyc("sw_fetch", v_fetch);
        cyc("sw_decode", v_dec);
        cyc("sw_maddr", v_maddr);
        mem_ready = 1'b0;
        cyc("sw_wr_wait", v_mwr);
        chk("sw_count_wait", {16'd0, instr_count}, 32'd3);
        mem_ready = 1'b1;
        cyc("sw_wr_done", v_mwr);
        chk("sw_count", {16'd0, instr_count}, 32'd4);

        // beq taken, bne not taken with ZERO = 1
        opcode = 6'b000100; ZERO = 1'b1;
        cyc("beq_fetch", v_fetch);
        cyc("beq_decode", v_dec);
        cyc("beq_branch", v_br_t);
        chk("beq_count", {16'd0, instr_count}, 32'd5);
        opcode = 6'b000101;
        cyc("bne_fetch", v_fetch);
        cyc("bne_decode", v_dec);
        cyc("bne_branch", v_br_n);
        chk("bne_count", {16'd0, instr_count}, 32'd6);
        ZERO = 1'b0;

        // jal, j, jr
        opcode = 6'b000011;
        cyc("jal_fetch", v_fetch);
        cyc("jal_decode", v_dec);
        cyc("jal_exec", v_jal);
        chk("jal_count", {16'd0, instr_count}, 32'd7);
        opcode = 6'b000010;
        cyc("j_fetch", v_fetch);
        cyc("j_decode", v_dec);
        cyc("j_exec", v_jump);
        opcode = 6'b000000; func = 6'b001000;
        cyc("jr_fetch", v_fetch);
        cyc("jr_decode", v_dec);
        cyc("jr_exec", v_jr);
        chk("jr_count", {16'd0, instr_count}, 32'd9);

        // andi
        opcode = 6'b001100;
        cyc("andi_fetch", v_fetch);
        cyc("andi_decode", v_dec);
        cyc("andi_iexec", v_iand);
        cyc("andi_iwb", v_iwb);
        chk("andi_count", {16'd0, instr_count}, 32'd10);

        // Illegal opcode traps; sticky until reset
        opcode = 6'b111111;
        cyc("trapop_fetch", v_fetch);
        cyc("trapop_decode", v_dec);
        chk("trapop_illegal", {31'd0, illegal}, 32'd1);
        cyc("trapop_trap1", v_trap);
        cyc("trapop_trap2", v_trap);
        chk("trapop_sticky", {31'd0, illegal}, 32'd1);
        chk("trapop_count", {16'd0, instr_count}, 32'd10);
        rst = 1'b1;
        #1;
        chk("trapop_rst_illegal", {31'd0, illegal}, 32'd0);
        chk("trapop_rst_count", {16'd0, instr_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Illegal R-type func traps from R_EXEC
        opcode = 6'b000000; func = 6'b000111;
        cyc("trapfn_fetch", v_fetch);
        cyc("trapfn_decode", v_dec);
        cyc("trapfn_rexec", v_radd);
        cyc("trapfn_trap", v_trap);
        chk("trapfn_illegal", {31'd0, illegal}, 32'd1);
        chk("trapfn_count", {16'd0, instr_count}, 32'd0);
        rst = 1'b1;

        // dut2: MEM_HS = 0 ignores mem_ready; 2-bit counter wraps
        mem_ready = 1'b0;
        opcode = 6'b001000; func = 6'b000000;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc2("addi2_fetch", v_fetch);
            cyc2("addi2_decode", v_dec);
            cyc2("addi2_iexec", v_iadd);
            cyc2("addi2_iwb", v_iwb);
            chk("addi2_count", {30'd0, instr_count2}, k % 4);
        end
        chk("dut_held_in_reset", {14'd0, w_outv}, {14'd0, v_rst});

        // Reset during MEM_WR aborts the store immediately
        opcode = 6'b101011;
        cyc2("sw2_fetch", v_fetch);
        cyc2("sw2_decode", v_dec);
        cyc2("sw2_maddr", v_maddr);
        chk("sw2_mwr", {14'd0, w_outv2}, {14'd0, v_mwr});
        rst2 = 1'b1;
        #1;
        chk("sw2_rst_outputs", {14'd0, w_outv2}, {14'd0, v_rst});
        chk("sw2_rst_count", {30'd0, instr_count2}, 32'd0);
        @(posedge clk);
        #1;
        chk("sw2_rst_hold_count", {30'd0, instr_count2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
